digit_serial_addsub: RTL and testbench

- Parametrised, multi-cycle adder/subtractor.
- Replaces the fixed 8-bit ripple adder wherever operand width exceeds what one cycle's carry chain can support.
- Consumes DIGIT bits per clock, LSB digit first, and carries between digits in a flop.
- Used by the wide sequential multiplier/accumulator datapath via a start/done handshake.

---
 rtl/digit_serial_addsub.sv | 137 +++++++++++++
 tb/tb_digit_serial_addsub.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: adds DIGIT bits per clock, LSB digit first,
// carrying between digits in a flop. Start/done handshake, NDIG cycles per op.

// One digit slice of the adder; purely combinational within a cycle.
module digit_serial_addsub_dig #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_c,
  output logic [DIGIT-1:0] o_s,
  output logic             o_co,
  output logic             o_cmsb
);
  logic [DIGIT:0] w_sum;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT{1'b0}}, i_c};
  assign o_s    = w_sum[DIGIT-1:0];
  assign o_co   = w_sum[DIGIT];
  // carry into the slice MSB, recovered from the MSB sum bit
  assign o_cmsb = i_a[DIGIT-1] ^ i_b[DIGIT-1] ^ w_sum[DIGIT-1];
endmodule

module digit_serial_addsub #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_s,
  output logic             o_co,
  output logic             o_ovf
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a, r_b, r_acc;
  logic [WIDTH-1:0] r_s;
  logic             r_co, r_ovf, r_done;

  logic             w_busy, w_accept, w_last;
  logic [DIGIT-1:0] w_dsum;
  logic             w_dco, w_dcmsb;
  logic [WIDTH-1:0] w_acc_nxt;

  // Operands are shifted right each RUN cycle, so the active digit is always
  // the low DIGIT bits; no digit-select mux is needed.
  digit_serial_addsub_dig #(.DIGIT(DIGIT)) u_dig (
    .i_a    (r_a[DIGIT-1:0]),
    .i_b    (r_b[DIGIT-1:0]),
    .i_c    (r_carry),
    .o_s    (w_dsum),
    .o_co   (w_dco),
    .o_cmsb (w_dcmsb)
  );

  // Result digits enter at the top and shift down; after NDIG digits the
  // LSB digit has reached bit 0.
  assign w_acc_nxt = (r_acc >> DIGIT) | (WIDTH'(w_dsum) << (WIDTH - DIGIT));
  assign w_last    = (r_cnt == CW'(NDIG - 1));

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic: accept in IDLE, return after the last digit
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_RUN;
      S_RUN:  if (w_last)  w_state_nxt = S_IDLE;
      default:             w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded control outputs
  always_comb begin
    w_busy   = (r_state == S_RUN);
    w_accept = (r_state == S_IDLE) && i_start;
  end

  // Datapath: latch operands on accept, add one digit per RUN cycle,
  // publish S/co/ovf only on the final digit
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a     <= i_a;
        r_b     <= i_sub ? ~i_b : i_b;
        r_carry <= i_sub | i_cin;
        r_cnt   <= '0;
      end else if (w_busy) begin
        r_a     <= r_a >> DIGIT;
        r_b     <= r_b >> DIGIT;
        r_carry <= w_dco;
        r_acc   <= w_acc_nxt;
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          r_s    <= w_acc_nxt;
          r_co   <= w_dco;
          r_ovf  <= w_dco ^ w_dcmsb;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = w_busy;
  assign o_done = r_done;
  assign o_s    = r_s;
  assign o_co   = r_co;
  assign o_ovf  = r_ovf;
endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: three instances (DIGIT=8, 32, 1, WIDTH=32)
// checked every cycle against a transaction-level model, plus directed
// literal expectations.
module tb_digit_serial_addsub;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  st;
  logic        sub, cin;
  logic [31:0] A, B;

  logic [2:0]  busy_o, done_o, co_o, ovf_o;
  logic [31:0] s_o [3];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  digit_serial_addsub #(.WIDTH(32), .DIGIT(8)) u_d8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(st[0]), .i_sub(sub), .i_a(A), .i_b(B),
    .i_cin(cin), .o_busy(busy_o[0]), .o_done(done_o[0]), .o_s(s_o[0]),
    .o_co(co_o[0]), .o_ovf(ovf_o[0]));
  digit_serial_addsub #(.WIDTH(32), .DIGIT(32)) u_d32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(st[1]), .i_sub(sub), .i_a(A), .i_b(B),
    .i_cin(cin), .o_busy(busy_o[1]), .o_done(done_o[1]), .o_s(s_o[1]),
    .o_co(co_o[1]), .o_ovf(ovf_o[1]));
  digit_serial_addsub #(.WIDTH(32), .DIGIT(1)) u_d1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(st[2]), .i_sub(sub), .i_a(A), .i_b(B),
    .i_cin(cin), .o_busy(busy_o[2]), .o_done(done_o[2]), .o_s(s_o[2]),
    .o_co(co_o[2]), .o_ovf(ovf_o[2]));

  function automatic int nd(input int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : 32;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- reference arithmetic from plain integer math ----
  logic [32:0]        c_sum;
  logic               c_co, c_ovf;
  logic signed [33:0] c_sg;
  always_comb begin
    c_sum = '0; c_co = 1'b0; c_sg = '0; c_ovf = 1'b0;
    if (sub) begin
      c_sum = {1'b0, A} - {1'b0, B};
      c_co  = (A >= B);
      c_sg  = $signed({{2{A[31]}}, A}) - $signed({{2{B[31]}}, B});
    end else begin
      c_sum = {1'b0, A} + {1'b0, B} + {32'd0, cin};
      c_co  = c_sum[32];
      c_sg  = $signed({{2{A[31]}}, A}) + $signed({{2{B[31]}}, B}) + $signed({33'd0, cin});
    end
    c_ovf = (c_sg > 34'sd2147483647) || (c_sg < -34'sd2147483648);
  end

  // ---- transaction model: accept when idle, result appears NDIG edges later ----
  logic        m_busy [3], m_done [3], m_co [3], m_ovf [3], m_pco [3], m_povf [3];
  logic [31:0] m_s [3], m_ps [3];
  int          m_left [3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_busy[k] <= 1'b0; m_done[k] <= 1'b0; m_s[k] <= '0;
        m_co[k] <= 1'b0; m_ovf[k] <= 1'b0; m_left[k] <= 0;
      end else begin
        m_done[k] <= 1'b0;
        if (m_busy[k]) begin
          m_left[k] <= m_left[k] - 1;
          if (m_left[k] == 1) begin
            m_busy[k] <= 1'b0; m_done[k] <= 1'b1;
            m_s[k] <= m_ps[k]; m_co[k] <= m_pco[k]; m_ovf[k] <= m_povf[k];
          end
        end else if (st[k]) begin
          m_busy[k] <= 1'b1; m_left[k] <= nd(k);
          m_ps[k] <= c_sum[31:0]; m_pco[k] <= c_co; m_povf[k] <= c_ovf;
        end
      end
    end
  end

  // ---- per-cycle compare against the model ----
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("busy[%0d]", k), {31'd0, busy_o[k]}, {31'd0, m_busy[k]});
        chk($sformatf("done[%0d]", k), {31'd0, done_o[k]}, {31'd0, m_done[k]});
        chk($sformatf("S[%0d]", k), s_o[k], m_s[k]);
        chk($sformatf("co[%0d]", k), {31'd0, co_o[k]}, {31'd0, m_co[k]});
        chk($sformatf("ovf[%0d]", k), {31'd0, ovf_o[k]}, {31'd0, m_ovf[k]});
      end
    end
  end

  function automatic logic [31:0] rv();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge with instance k idle (or in its done cycle). Returns
  // at the negedge where done is seen.
  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic sb,
                        input logic [31:0] es, input logic eco, input logic eovf,
                        input bit repulse, input bit hold_chk, input logic [31:0] hold_s,
                        input string nm);
    int n;
    A = a; B = b; cin = c; sub = sb; st[k] = 1'b1;
    @(negedge clk);
    st[k] = 1'b0;
    A = $urandom; B = $urandom; cin = $urandom; sub = $urandom;
    chk({nm, "_busy"}, {31'd0, busy_o[k]}, 32'd1);
    n = 0;
    while (done_o[k] !== 1'b1 && n < 100) begin
      if (hold_chk) chk({nm, "_hold"}, s_o[k], hold_s);
      st[k] = (repulse && n == 1);
      @(negedge clk);
      n++;
      A = $urandom; B = $urandom;
    end
    st[k] = 1'b0;
    chk({nm, "_lat"}, n, nd(k));
    chk({nm, "_S"}, s_o[k], es);
    chk({nm, "_co"}, {31'd0, co_o[k]}, {31'd0, eco});
    chk({nm, "_ovf"}, {31'd0, ovf_o[k]}, {31'd0, eovf});
    chk({nm, "_idle"}, {31'd0, busy_o[k]}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; st = '0; sub = 1'b0; cin = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", {29'd0, busy_o}, 32'd0);
    chk("rst_done", {29'd0, done_o}, 32'd0);
    chk("rst_S", s_o[0], 32'd0);
    chk("rst_co_ovf", {26'd0, co_o, ovf_o}, 32'd0);
    chk_en = 1'b1;

    // directed, DIGIT=8
    run_op(0, 32'h0000_00FF, 32'h1, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 0, 0, 0, "intra");
    run_op(0, 32'h0000_0001, 32'h2, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 0, 1, 32'h100, "b2b");
    run_op(0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0, 0, 0, "ripple");
    run_op(0, 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 0, 0, 0, "sub57");
    run_op(0, 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 0, 0, 0, "subovf");
    run_op(0, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0, 0, 0, "addovf");
    run_op(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1, 0, 0, "repulse");
    repeat (2) @(negedge clk);

    // reset in the middle of a RUN: sampled at E2
    A = 32'hDEAD_BEEF; B = 32'h1; sub = 1'b0; cin = 1'b0; st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    chk("mid_busy", {31'd0, busy_o[0]}, 32'd1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("mid_rst_busy", {31'd0, busy_o[0]}, 32'd0);
    chk("mid_rst_S", s_o[0], 32'd0);
    for (int i = 0; i < 6; i++) chk("mid_no_done", {31'd0, done_o[0]}, 32'd0);
    repeat (6) begin
      @(negedge clk);
      chk("mid_no_done_cyc", {31'd0, done_o[0]}, 32'd0);
    end
    run_op(0, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_0031, 1'b0, 1'b0, 0, 0, 0, "after_rst");

    // degenerate and bit-serial widths
    run_op(1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 0, 0, 0, "d32_ripple");
    run_op(2, 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 0, 0, 0, "d1_subovf");
    run_op(2, 32'h0000_00FF, 32'h1, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 0, 0, 0, "d1_intra");

    // randomized traffic on all three, including starts while busy and one reset
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      A = rv(); B = rv(); cin = $urandom; sub = $urandom;
      st = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      rst_n = (c != 700);
    end
    @(negedge clk);
    st = '0; rst_n = 1'b1;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
